// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: basic machine types shared by every pipeline stage.
//   word_t : 32-bit machine word (instructions, addresses, data).
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage : cpu_types_pkg

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the pipeline stages and their
// inter-stage latches.
//   fetch_state_t : fetch-stage control states (RUN, HOLD, HALTED).
//   ifid_t        : contents of the IF/ID pipeline latch.
//   NOP_INSTR     : instruction word used for a bubble.
//   align_word()  : clears the byte-offset bits of an address.
package pipeline_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HOLD   = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    localparam word_t NOP_INSTR   = 32'h0000_0000;
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, npc: 32'h0000_0000, valid: 1'b0};

    // Instruction addresses are word aligned; the two byte-offset bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage : pipeline_pkg

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundle of the fetch-stage connections, shaped like the
// other stage interfaces.
//   modport fs : the fetch stage itself (icache/hazard/EX inputs, IF/ID outputs).
//   modport tb : the environment driving the stage.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  stall;
    logic  flush;
    word_t redirect_pc;
    logic  halt;
    word_t ifid_instr;
    word_t ifid_npc;
    logic  ifid_valid;

    modport fs (
        input  ihit, imemload, stall, flush, redirect_pc, halt,
        output iREN, iaddr, ifid_instr, ifid_npc, ifid_valid
    );

    modport tb (
        output ihit, imemload, stall, flush, redirect_pc, halt,
        input  iREN, iaddr, ifid_instr, ifid_npc, ifid_valid
    );
endinterface : fetch_stage_if

// File: rtl/ifid_latch.sv
// ifid_latch: generic IF/ID-style pipeline register.
//   clk, rst : clock and asynchronous active-high reset (reset -> bubble).
//   load     : capture d on the rising edge.
//   clear    : load a bubble; wins over load.
//   d, q     : latch input and registered output.
module ifid_latch
    import pipeline_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t q_r;

    // Latch register: clear takes priority so a squash always wins over a capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= IFID_BUBBLE;
        end else if (clear) begin
            q_r <= IFID_BUBBLE;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : ifid_latch

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, requests words from the
// icache and fills the IF/ID latch. A one-entry skid buffer holds a word that
// returns while decode is stalled so it is never fetched twice.
//   CLK, RST              : clock, asynchronous active-high reset.
//   ihit, imemload        : icache response for iaddr.
//   iREN, iaddr           : icache read request (decoded from state and PC).
//   stall                 : hold IF/ID (load-use hazard).
//   flush, redirect_pc    : EX-stage redirect; squashes IF/ID.
//   halt                  : decode holds HALT; stage parks until reset.
//   ifid_instr/npc/valid  : registered IF/ID latch contents.
module fetch_stage
    import cpu_types_pkg::*;
    import pipeline_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  stall,
    input  logic  flush,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid
);

    fetch_state_t state_r, state_s;
    word_t        pc_r, pc_s;
    word_t        buf_instr_r, buf_instr_s;
    word_t        buf_npc_r, buf_npc_s;
    word_t        pc_plus4_s;
    logic         ifid_load_s;
    logic         ifid_clear_s;
    ifid_t        ifid_d_s;
    ifid_t        ifid_q_s;

    // pc+4 naturally wraps at the top of the address space.
    assign pc_plus4_s = pc_r + 32'd4;

    // Next-state decode: flush beats halt, halt beats the stall/ihit rules.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        buf_instr_s  = buf_instr_r;
        buf_npc_s    = buf_npc_r;
        ifid_load_s  = 1'b0;
        ifid_clear_s = 1'b0;
        ifid_d_s     = '{instr: imemload, npc: pc_plus4_s, valid: 1'b1};

        case (state_r)
            RUN, HOLD: begin
                if (flush) begin
                    pc_s         = align_word(redirect_pc);
                    buf_instr_s  = 32'h0000_0000;
                    buf_npc_s    = 32'h0000_0000;
                    ifid_clear_s = 1'b1;
                    state_s      = RUN;
                end else if (halt) begin
                    ifid_clear_s = 1'b1;
                    state_s      = HALTED;
                end else if (state_r == HOLD) begin
                    // No request is outstanding in HOLD, so ihit is meaningless here.
                    if (!stall) begin
                        ifid_d_s    = '{instr: buf_instr_r, npc: buf_npc_r, valid: 1'b1};
                        ifid_load_s = 1'b1;
                        state_s     = RUN;
                    end else begin
                        state_s = HOLD;
                    end
                end else if (ihit && !stall) begin
                    ifid_load_s = 1'b1;
                    pc_s        = pc_plus4_s;
                end else if (ihit) begin
                    // Word arrived during a stall: park it rather than refetch later.
                    buf_instr_s = imemload;
                    buf_npc_s   = pc_plus4_s;
                    pc_s        = pc_plus4_s;
                    state_s     = HOLD;
                end else if (!stall) begin
                    ifid_clear_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            HALTED: begin
                state_s = HALTED;
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // Control state, PC and skid buffer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= RUN;
            pc_r        <= PC_INIT;
            buf_instr_r <= 32'h0000_0000;
            buf_npc_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            buf_instr_r <= buf_instr_s;
            buf_npc_r   <= buf_npc_s;
        end
    end

    ifid_latch u_ifid (
        .clk   (CLK),
        .rst   (RST),
        .load  (ifid_load_s),
        .clear (ifid_clear_s),
        .d     (ifid_d_s),
        .q     (ifid_q_s)
    );

    assign iREN       = (state_r == RUN);
    assign iaddr      = pc_r;
    assign ifid_instr = ifid_q_s.instr;
    assign ifid_npc   = ifid_q_s.npc;
    assign ifid_valid = ifid_q_s.valid;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage. Each stimulus
// step pushes the hand-computed post-edge outputs into a queue; a monitor
// pops and compares on every falling edge (or on demand for async reset).
module tb_fetch_stage;
    import cpu_types_pkg::*;
    import pipeline_pkg::*;

    localparam word_t PC0 = 32'h0000_0100;

    typedef struct {
        string nm;
        logic  ren;
        word_t addr;
        word_t instr;
        word_t npc;
        logic  valid;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    event sample_ev;

    fetch_stage_if fif ();

    fetch_stage #(.PC_INIT(PC0)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (fif.ihit),
        .imemload    (fif.imemload),
        .iREN        (fif.iREN),
        .iaddr       (fif.iaddr),
        .stall       (fif.stall),
        .flush       (fif.flush),
        .redirect_pc (fif.redirect_pc),
        .halt        (fif.halt),
        .ifid_instr  (fif.ifid_instr),
        .ifid_npc    (fif.ifid_npc),
        .ifid_valid  (fif.ifid_valid)
    );

    always #5 CLK = ~CLK;

    // Distinctive instruction word for a given fetch address.
    function automatic word_t wd(input word_t a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK or sample_ev);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                tests++;
                if (fif.iREN !== e.ren || fif.iaddr !== e.addr || fif.ifid_instr !== e.instr ||
                    fif.ifid_npc !== e.npc || fif.ifid_valid !== e.valid) begin
                    fails++;
                    $display("FAIL %s: got iREN=%0b iaddr=%h instr=%h npc=%h valid=%0b, expected iREN=%0b iaddr=%h instr=%h npc=%h valid=%0b",
                             e.nm, fif.iREN, fif.iaddr, fif.ifid_instr, fif.ifid_npc, fif.ifid_valid,
                             e.ren, e.addr, e.instr, e.npc, e.valid);
                end
            end
        end
    end

    task automatic drive(input logic ih, input logic st, input logic fl, input logic hl,
                         input word_t im, input word_t rpc);
        fif.ihit        = ih;
        fif.stall       = st;
        fif.flush       = fl;
        fif.halt        = hl;
        fif.imemload    = im;
        fif.redirect_pc = rpc;
    endtask

    // One clock of stimulus; the expectation describes outputs after the edge.
    task automatic step(input string nm, input logic ih, input logic st, input logic fl,
                        input logic hl, input word_t im, input word_t rpc,
                        input logic eren, input word_t eaddr, input word_t einstr,
                        input word_t enpc, input logic ev);
        @(negedge CLK);
        drive(ih, st, fl, hl, im, rpc);
        @(posedge CLK);
        sbq.push_back('{nm, eren, eaddr, einstr, enpc, ev});
    endtask

    // Assert reset between clock edges and check the values appear at once.
    task automatic pulse_reset(input string nm);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 RST = 1'b1;
        #1 sbq.push_back('{nm, 1'b1, PC0, 32'h0, 32'h0, 1'b0});
        -> sample_ev;
        @(negedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 sbq.push_back('{"reset", 1'b1, PC0, 32'h0, 32'h0, 1'b0});
        -> sample_ev;
        @(negedge CLK);
        #1 RST = 1'b0;

        // Sequential fetch from PC_INIT.
        step("fetch100",   1, 0, 0, 0, wd(32'h100), 32'h0,   1, 32'h108 - 32'h4, wd(32'h100), 32'h104, 1);
        step("fetch104",   1, 0, 0, 0, wd(32'h104), 32'h0,   1, 32'h108, wd(32'h104), 32'h108, 1);
        step("miss",       0, 0, 0, 0, 32'h0,       32'h0,   1, 32'h108, 32'h0, 32'h0, 0);
        // Redirect with unaligned target.
        step("flush_align",1, 0, 1, 0, 32'h5555,    32'h1FF, 1, 32'h1FC, 32'h0, 32'h0, 0);
        step("fetch1fc",   1, 0, 0, 0, wd(32'h1FC), 32'h0,   1, 32'h200, wd(32'h1FC), 32'h200, 1);
        // Word @0x200 arrives under stall: parked, IF/ID held.
        step("stall_hit",  1, 1, 0, 0, wd(32'h200), 32'h0,   0, 32'h204, wd(32'h1FC), 32'h200, 1);
        step("hold1",      1, 1, 0, 0, 32'hDEADBEEF,32'h0,   0, 32'h204, wd(32'h1FC), 32'h200, 1);
        step("hold2",      1, 1, 0, 0, 32'hDEADBEEF,32'h0,   0, 32'h204, wd(32'h1FC), 32'h200, 1);
        step("release",    1, 0, 0, 0, 32'hBAD0BAD0,32'h0,   1, 32'h204, wd(32'h200), 32'h204, 1);
        step("fetch204",   1, 0, 0, 0, wd(32'h204), 32'h0,   1, 32'h208, wd(32'h204), 32'h208, 1);
        step("miss_stall", 0, 1, 0, 0, 32'h0,       32'h0,   1, 32'h208, wd(32'h204), 32'h208, 1);
        // Flush while holding a parked word.
        step("stall_hit2", 1, 1, 0, 0, wd(32'h208), 32'h0,   0, 32'h20C, wd(32'h204), 32'h208, 1);
        step("flush_hold", 1, 1, 1, 0, 32'h1234,    32'h400, 1, 32'h400, 32'h0, 32'h0, 0);
        step("post_flush", 0, 0, 0, 0, 32'h0,       32'h0,   1, 32'h400, 32'h0, 32'h0, 0);
        step("stall_hit4", 1, 1, 0, 0, wd(32'h400), 32'h0,   0, 32'h404, 32'h0, 32'h0, 0);
        step("release400", 0, 0, 0, 0, 32'h0,       32'h0,   1, 32'h404, wd(32'h400), 32'h404, 1);
        // Flush beats halt.
        step("halt_flush", 1, 0, 1, 1, 32'h77,      32'h300, 1, 32'h300, 32'h0, 32'h0, 0);
        step("fetch300",   1, 0, 0, 0, wd(32'h300), 32'h0,   1, 32'h304, wd(32'h300), 32'h304, 1);
        // PC wrap at top of address space.
        step("flush_top",  0, 0, 1, 0, 32'h0,       32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        step("fetch_wrap", 1, 0, 0, 0, 32'h1357_9BDF, 32'h0, 1, 32'h0, 32'h1357_9BDF, 32'h0, 1);
        step("wrap_miss",  0, 0, 0, 0, 32'h0,       32'h0,   1, 32'h0, 32'h0, 32'h0, 0);
        step("fetch0",     1, 0, 0, 0, wd(32'h0),   32'h0,   1, 32'h4, wd(32'h0), 32'h4, 1);
        // Halt parks the stage; flush and ihit are ignored afterwards.
        step("halt",       1, 0, 0, 1, wd(32'h4),   32'h0,   0, 32'h4, 32'h0, 32'h0, 0);
        step("halted_fl",  1, 0, 1, 0, wd(32'h4),   32'h800, 0, 32'h4, 32'h0, 32'h0, 0);
        step("halted_hit", 1, 0, 0, 0, wd(32'h4),   32'h0,   0, 32'h4, 32'h0, 32'h0, 0);
        pulse_reset("rst_halted");
        step("fetch_rst",  1, 0, 0, 0, wd(32'h100), 32'h0,   1, 32'h104, wd(32'h100), 32'h104, 1);
        step("stall_rst",  1, 1, 0, 0, wd(32'h104), 32'h0,   0, 32'h108, wd(32'h100), 32'h104, 1);
        pulse_reset("rst_midop");
        step("hold_gone",  0, 0, 0, 0, 32'h0,       32'h0,   1, 32'h100, 32'h0, 32'h0, 0);

        repeat (2) @(negedge CLK);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_stage
